mux_fases: RTL



---
 rtl/mux_fases.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux_fases.sv
`default_nettype none
// ============================================================================
//  Module   : mux_fases
//  Purpose  : Phase-slotted N-to-1 register multiplexer. A free-running
//             modulo-PERIOD phase counter picks one edge per instruction
//             period. On that edge the word selected by `control` is latched
//             into a held output register.
//
//  Ports    : clock     - system clock, rising edge
//             reset     - synchronous, active-high, overrides everything
//             stall     - freezes the phase counter and suppresses capture
//             control   - input select, only looked at on capture edges
//             entradas  - NUM_IN packed words, word k = [k*WIDTH +: WIDTH]
//             saida     - captured word, held between captures
//             valido    - one-cycle pulse in the cycle after each capture
//             erro_sel  - sticky: a capture saw control >= NUM_IN
//             fase      - current phase counter value
//
//  Revision : 1.0 - initial release
// ============================================================================
module mux_fases #(
    parameter int WIDTH         = 32,
    parameter int NUM_IN        = 4,
    parameter int SEL_W         = 2,
    parameter int PERIOD        = 10,
    parameter int CAPTURE_PHASE = 4,
    parameter int PHASE_W       = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [SEL_W-1:0]          control,
    input  logic [NUM_IN*WIDTH-1:0]   entradas,
    output logic [WIDTH-1:0]          saida,
    output logic                      valido,
    output logic                      erro_sel,
    output logic [PHASE_W-1:0]        fase
);

    // One extra bit so the range check also works when NUM_IN == 2**SEL_W.
    localparam logic [SEL_W:0]   c_NUM_IN   = (SEL_W+1)'(NUM_IN);
    localparam logic [PHASE_W-1:0] c_LAST   = PHASE_W'(PERIOD - 1);
    localparam logic [PHASE_W-1:0] c_CAPTURE = PHASE_W'(CAPTURE_PHASE);

    logic [PHASE_W-1:0] r_fase;
    logic [WIDTH-1:0]   r_saida;
    logic               r_valido;
    logic               r_erro;

    logic [PHASE_W-1:0] w_fase_next;
    logic               w_capture;
    logic               w_sel_ok;
    logic [WIDTH-1:0]   w_sel_word;

    // Counter wraps explicitly at PERIOD-1, so it never reaches PERIOD even
    // when PERIOD is not a power of two.
    assign w_fase_next = (r_fase == c_LAST) ? '0 : r_fase + PHASE_W'(1);

    // Capture is keyed on the phase being entered, not the current one; a
    // stalled edge never advances the counter, so a pending capture simply
    // waits for the counter to move again.
    assign w_capture = !stall && (w_fase_next == c_CAPTURE);

    assign w_sel_ok = ({1'b0, control} < c_NUM_IN);

    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (control == SEL_W'(k)) begin
                w_sel_word = entradas[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fase   <= '0;
            r_saida  <= '0;
            r_valido <= 1'b0;
            r_erro   <= 1'b0;
        end else if (stall) begin
            r_valido <= 1'b0;
        end else begin
            r_fase   <= w_fase_next;
            r_valido <= w_capture;
            if (w_capture) begin
                // Out-of-range select still produces a strobe but keeps the
                // previous word and flags the error until the next reset.
                if (w_sel_ok) begin
                    r_saida <= w_sel_word;
                end else begin
                    r_erro  <= 1'b1;
                end
            end
        end
    end

    assign saida    = r_saida;
    assign valido   = r_valido;
    assign erro_sel = r_erro;
    assign fase     = r_fase;

endmodule
`default_nettype wire
